// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared types and defaults for the input conditioner
package input_conditioner_pkg;

    typedef enum logic [1:0] {LOW, RISING, HIGH, FALLING} deb_state_t;

    localparam int DEFAULT_N_IN          = 2;
    localparam int DEFAULT_STABLE_CYCLES = 500_000;

    // Stability counter width; clamped to 1 so a bad parameter still elaborates far enough to hit the check
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one synchronised, debounced input channel with edge pulses and toggle
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_toggle
);

    localparam int                CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_toggle;

    // Two-flop synchroniser; the FSM only ever looks at r_s2
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM: a candidate level must persist for STABLE_CYCLES samples; any reversal restarts from scratch
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state  <= LOW;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            // Edge pulses last one cycle unless re-armed below
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (r_s2) begin
                        r_state <= RISING;
                        r_cnt   <= '0;
                    end
                end
                RISING: begin
                    if (!r_s2) begin
                        r_state <= LOW;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state  <= HIGH;
                        r_level  <= 1'b1;
                        r_rise   <= 1'b1;
                        r_toggle <= ~r_toggle;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!r_s2) begin
                        r_state <= FALLING;
                        r_cnt   <= '0;
                    end
                end
                FALLING: begin
                    if (r_s2) begin
                        r_state <= HIGH;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= LOW;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N_IN independent debounced board input channels
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_IN          = DEFAULT_N_IN,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic            fpga_CLK,
    input  logic            fpga_NRST,
    input  logic [N_IN-1:0] in_raw,
    output logic [N_IN-1:0] out_level,
    output logic [N_IN-1:0] out_rise,
    output logic [N_IN-1:0] out_fall,
    output logic [N_IN-1:0] out_toggle
);

    // Reject configurations where a single sample would count as stable
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("input_conditioner: STABLE_CYCLES must be at least 2");
    end
    if (N_IN < 1) begin : g_bad_n_in
        $error("input_conditioner: N_IN must be at least 1");
    end

    logic [N_IN-1:0] w_level;
    logic [N_IN-1:0] w_rise;
    logic [N_IN-1:0] w_fall;
    logic [N_IN-1:0] w_toggle;

    // One fully independent debouncer per pin
    for (genvar g = 0; g < N_IN; g++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .i_clk    (fpga_CLK),
            .i_resetn (fpga_NRST),
            .i_raw    (in_raw[g]),
            .o_level  (w_level[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g]),
            .o_toggle (w_toggle[g])
        );
    end

    assign out_level  = w_level;
    assign out_rise   = w_rise;
    assign out_fall   = w_fall;
    assign out_toggle = w_toggle;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions raw board inputs (slide switches, push-buttons) before they reach design logic; it is the input-side counterpart of the LED output path. Each of `N_IN` channels is synchronised into the `fpga_CLK` domain and debounced by a stability counter. Each channel then produces a clean level, one-cycle rise and fall pulses, and a toggle bit. It sits between the `fpga_SW*`/button pins and any control logic in the top level.

## Interface
- `N_IN`, default 2: number of independent input channels.
- `STABLE_CYCLES`, default 500_000: consecutive identical synchronised samples required to accept a new level. 10 ms at 50 MHz. Must be ≥ 2; enforced by an elaboration-time assertion.
- `fpga_CLK`  in  1: 50 MHz clock, the only clock in the block.
- `fpga_NRST`  in  1: reset, synchronous, active-low.
- `in_raw`  in  N_IN: asynchronous raw pin levels.
- `out_level`  out  N_IN: debounced level.
- `out_rise`  out  N_IN: one-cycle pulse when `out_level` goes 0→1.
- `out_fall`  out  N_IN: one-cycle pulse when `out_level` goes 1→0.
- `out_toggle`  out  N_IN: flips on every `out_rise`.

## Operation
- Per channel, the raw input passes through a 2-flop synchroniser `s1`→`s2`. The FSM only ever sees `s2`.
- FSM states are LOW, RISING, HIGH, FALLING. The counter `cnt` has width `$clog2(STABLE_CYCLES)`.
- LOW:
  - `s2`=1 → RISING, `cnt`←0.
- RISING:
  - `s2`=0 → LOW. This is a bounce; no output changes.
  - `s2`=1 and `cnt`==STABLE_CYCLES-1 → HIGH, `out_level`←1, `out_rise`←1, `out_toggle`←~`out_toggle`.
  - Otherwise `cnt`++.
- HIGH / FALLING: mirror of LOW / RISING with polarity swapped. Acceptance of the low level sets `out_fall`←1 and leaves `out_toggle` unchanged.
- `out_rise` and `out_fall` are high for exactly one cycle. They are never asserted together on one channel.
- Channels are fully independent. Simultaneous events on different channels are each handled normally.
- `cnt` never wraps: it is compared before increment and is only advanced in RISING or FALLING.
- Reset while low: on any rising edge with `fpga_NRST`=0, every channel clears regardless of its state, including mid-count:
  - `s1`, `s2`, `cnt` = 0; state = LOW.
  - `out_level`, `out_rise`, `out_fall`, `out_toggle` = 0.
- Reset release: an input already held high at reset release is seen as a normal 0→1 transition. It produces one `out_rise` after the full latency.

## Timing
- All outputs are registered; there is no combinational path from `in_raw` to any output.
- Latency: take the edge at which `s1` first samples a value that then stays stable as edge 0.
  - `out_level` changes and the pulse asserts at edge STABLE_CYCLES+2.
  - The pulse deasserts at edge STABLE_CYCLES+3.
- Bounce rejection: any glitch on `s2` that returns before the count completes restarts acceptance from scratch. Acceptance then takes a full STABLE_CYCLES again after the input settles.
- Minimum accepted pulse width on `in_raw`: STABLE_CYCLES+1 cycles. Shorter pulses produce no output activity.

## Structure
- Package `input_conditioner_pkg`: `typedef enum logic [1:0] {LOW, RISING, HIGH, FALLING} deb_state_t;`
- Sub-module `debounce_channel`, one per channel:
  - contains the synchroniser, FSM, counter and the four output bits;
  - parameter `STABLE_CYCLES`.
- `input_conditioner` instantiates `N_IN` copies in a generate loop and concatenates their outputs.

## Test plan
All scenarios use `N_IN`=2, `STABLE_CYCLES`=4.
- Reset: hold `fpga_NRST`=0 for 3 cycles with `in_raw`=2'b11 → all outputs 0 throughout. After release, both channels show `out_rise` together at edge 6 after the first sample, and `out_toggle`=2'b11.
- Clean step: `in_raw[0]` 0→1 held → `out_level[0]`=1 and a single-cycle `out_rise[0]` at edge 6, next cycle `out_rise[0]`=0. Then 1→0 → `out_fall[0]` pulse 6 edges later; `out_toggle[0]` stays 1.
- Bounce: `in_raw[1]` 1 for 3 cycles, 0 for 1, then 1 held → no output during the bounce. `out_rise[1]` comes 6 edges after the final rise.
- Short pulse: `in_raw[0]` high for 4 cycles, then low → `out_level[0]`, `out_rise[0]`, `out_fall[0]` all stay 0. With a 5-cycle pulse → one rise, then one fall.
- Independence and toggle:
  - Press `in_raw[0]` three times, clean, 20 cycles apart → `out_toggle[0]` sequence 1,0,1.
  - Channel 1 toggles on its own presses simultaneously with no crosstalk.
- Reset mid-count: assert `fpga_NRST`=0 for 1 cycle while channel 0 is in RISING with `cnt`=2 → all outputs 0 next cycle. The rise is accepted only after a full 6-edge latency measured from reset release.
